// File: rtl/branch_predict_ctrl.sv
// Branch predictor and Fetch redirect controller: 2-bit saturating counters
// predict in Decode, resolution in Execute drives PC select, flushes and training.
module branch_predict_ctrl #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCD,
    input  logic [1:0]  BranchTypeD,
    input  logic        StallD,
    input  logic [31:0] PCE,
    input  logic [1:0]  BranchTypeE,
    input  logic [1:0]  PCSrcE,
    output logic [1:0]  PCSelF,
    output logic        FlushD,
    output logic        FlushE,
    output logic        PredTakenE,
    output logic [15:0] MispredCnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    typedef enum logic [1:0] {
        SEL_PLUS4F   = 2'b00,
        SEL_TARGETD  = 2'b01,
        SEL_TARGETE  = 2'b10,
        SEL_PLUS4E   = 2'b11
    } pc_sel_t;

    logic [1:0]          ctr_table [ENTRIES];
    logic [IDX_BITS-1:0] idx_d;
    logic [IDX_BITS-1:0] idx_e;
    logic                cond_d;
    logic                cond_e;
    logic                taken_e;
    logic                pred_d;
    logic                pred_e;
    logic                e_action;
    pc_sel_t             pc_sel;

    // Only the word-index bits of the PCs select a counter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCD[31:IDX_BITS+2], PCD[1:0], PCE[31:IDX_BITS+2], PCE[1:0]};

    assign idx_d   = PCD[IDX_BITS+1:2];
    assign idx_e   = PCE[IDX_BITS+1:2];
    assign cond_d  = (BranchTypeD == 2'b01) || (BranchTypeD == 2'b10);
    assign cond_e  = (BranchTypeE == 2'b01) || (BranchTypeE == 2'b10);
    assign taken_e = (PCSrcE != 2'b00);
    // Read sees the pre-update counter when Execute trains the same entry.
    assign pred_d  = cond_d && ctr_table[idx_d][1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pc_sel   = SEL_PLUS4F;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        e_action = 1'b0;
        if (cond_e && pred_e && !taken_e) begin
            pc_sel   = SEL_PLUS4E;
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            e_action = 1'b1;
        end else if (cond_e && !pred_e && taken_e) begin
            pc_sel   = SEL_TARGETE;
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            e_action = 1'b1;
        end else if (!cond_e && taken_e) begin
            pc_sel   = SEL_TARGETE;
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            e_action = 1'b1;
        end else if (pred_d && !StallD) begin
            pc_sel = SEL_TARGETD;
            FlushD = 1'b1;
        end
    end

    assign PCSelF     = pc_sel;
    assign PredTakenE = pred_e;

    // A stalled Decode sends a bubble into Execute, so the prediction is dropped.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            pred_e <= 1'b0;
        end else if (FlushE || StallD) begin
            pred_e <= 1'b0;
        end else begin
            pred_e <= pred_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the counter table is reset because every entry must start at weak-not-taken.
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_table[i] <= 2'b01;
            end
        end else if (cond_e) begin
            if (taken_e && ctr_table[idx_e] != 2'b11) begin
                ctr_table[idx_e] <= ctr_table[idx_e] + 2'd1;
            end else if (!taken_e && ctr_table[idx_e] != 2'b00) begin
                ctr_table[idx_e] <= ctr_table[idx_e] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MispredCnt <= 16'h0000;
        end else if (e_action && MispredCnt != 16'hFFFF) begin
            MispredCnt <= MispredCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: directed cycles push hand-computed
// expectations; a negedge monitor pops and compares the combinational outputs.
module tb_branch_predict_ctrl;

    typedef struct {
        string       name;
        logic [1:0]  pcsel;
        logic        flush_d;
        logic        flush_e;
        logic        pred_e;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PCD = '0;
    logic [1:0]  BranchTypeD = '0;
    logic        StallD = 1'b0;
    logic [31:0] PCE = '0;
    logic [1:0]  BranchTypeE = '0;
    logic [1:0]  PCSrcE = '0;
    logic [1:0]  PCSelF;
    logic        FlushD;
    logic        FlushE;
    logic        PredTakenE;
    logic [15:0] MispredCnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    branch_predict_ctrl #(.IDX_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .PCD(PCD), .BranchTypeD(BranchTypeD), .StallD(StallD),
        .PCE(PCE), .BranchTypeE(BranchTypeE), .PCSrcE(PCSrcE),
        .PCSelF(PCSelF), .FlushD(FlushD), .FlushE(FlushE),
        .PredTakenE(PredTakenE), .MispredCnt(MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".PCSelF"},     16'(PCSelF),     16'(e.pcsel));
            check({e.name, ".FlushD"},     16'(FlushD),     16'(e.flush_d));
            check({e.name, ".FlushE"},     16'(FlushE),     16'(e.flush_e));
            check({e.name, ".PredTakenE"}, 16'(PredTakenE), 16'(e.pred_e));
            check({e.name, ".MispredCnt"}, MispredCnt,      e.cnt);
        end
    end

    task automatic drive(input logic [31:0] pcd, input logic [1:0] btd, input logic stall,
                         input logic [31:0] pce, input logic [1:0] bte, input logic [1:0] src);
        @(posedge clk);
        #1;
        PCD = pcd; BranchTypeD = btd; StallD = stall;
        PCE = pce; BranchTypeE = bte; PCSrcE = src;
    endtask

    task automatic step(input string name,
                        input logic [31:0] pcd, input logic [1:0] btd, input logic stall,
                        input logic [31:0] pce, input logic [1:0] bte, input logic [1:0] src,
                        input logic [1:0] pcsel, input logic fd, input logic fe,
                        input logic pe, input logic [15:0] cnt);
        exp_t e;
        drive(pcd, btd, stall, pce, bte, src);
        e.name = name; e.pcsel = pcsel; e.flush_d = fd; e.flush_e = fe;
        e.pred_e = pe; e.cnt = cnt;
        sb.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // Reset held: all outputs at reset values.
        @(posedge clk);
        #1;
        e.name = "reset"; e.pcsel = 2'b00; e.flush_d = 0; e.flush_e = 0; e.pred_e = 0; e.cnt = 16'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //    name        PCD    BTD  st PCE    BTE  src  sel  FD FE PE cnt
        step("bq_wnt",   32'h40, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'd0);
        step("bq_misp",  32'h44, 2'b00, 0, 32'h40, 2'b01, 2'b01, 2'b10, 1, 1, 0, 16'd0);
        step("bq_wt",    32'h40, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b01, 1, 0, 0, 16'd1);
        step("bq_ok",    32'h0,  2'b00, 0, 32'h40, 2'b01, 2'b01, 2'b00, 0, 0, 1, 16'd1);
        // Train idx 5 taken three times from weak-NT.
        step("t5_tk1",   32'h0,  2'b00, 0, 32'h14, 2'b01, 2'b01, 2'b10, 1, 1, 0, 16'd1);
        step("t5_tk2",   32'h0,  2'b00, 0, 32'h14, 2'b01, 2'b01, 2'b10, 1, 1, 0, 16'd2);
        step("t5_tk3",   32'h0,  2'b00, 0, 32'h14, 2'b01, 2'b01, 2'b10, 1, 1, 0, 16'd3);
        // Not-taken resolve while D reads same entry: D sees strong-T pre-update.
        step("t5_nt1",   32'h14, 2'b01, 0, 32'h14, 2'b01, 2'b00, 2'b01, 1, 0, 0, 16'd4);
        step("t5_wt",    32'h14, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b01, 1, 0, 1, 16'd4);
        // Predicted-taken bne resolves not-taken: E wins over predD.
        step("t5_nt2",   32'h14, 2'b10, 0, 32'h14, 2'b10, 2'b00, 2'b11, 1, 1, 1, 16'd4);
        step("t5_wnt",   32'h14, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'd5);
        // Jal in E (PC 0x54 also maps to idx 5) while predD=1: no table write.
        step("jal_e",    32'h40, 2'b01, 0, 32'h54, 2'b00, 2'b01, 2'b10, 1, 1, 0, 16'd5);
        step("jal_nowr", 32'h14, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'd6);
        // Stall suppresses D redirect and clears predE.
        step("stall",    32'h40, 2'b01, 1, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'd6);
        step("unstall",  32'h40, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b01, 1, 0, 0, 16'd6);
        step("pred_car", 32'h0,  2'b00, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 1, 16'd6);
        step("rsv_type", 32'h40, 2'b11, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'd6);

        // Saturate the redirect counter with 0xFFFF+2 jalr redirects.
        for (int i = 0; i < 65537; i++) begin
            drive(32'h0, 2'b00, 1'b0, 32'h80, 2'b00, 2'b10);
        end
        step("sat_hold", 32'h0,  2'b00, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'hFFFF);
        step("sat_jal",  32'h0,  2'b00, 0, 32'h80, 2'b00, 2'b10, 2'b10, 1, 1, 0, 16'hFFFF);
        step("sat_keep", 32'h40, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b01, 1, 0, 0, 16'hFFFF);

        // predE=1 now; a pending mispredict is killed by a mid-cycle reset.
        drive(32'h40, 2'b01, 1'b0, 32'h40, 2'b01, 2'b00);
        rst = 1'b1;
        e.name = "rst_mid"; e.pcsel = 2'b00; e.flush_d = 0; e.flush_e = 0; e.pred_e = 0; e.cnt = 16'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rst_tbl0", 32'h40, 2'b01, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'd0);
        step("rst_ok",   32'h0,  2'b00, 0, 32'h0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 16'd0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
